sync_fifo_param: RTL and testbench

Parametrised synchronous FIFO. It is the next generation of the team's fixed 8-bit FIFO, generalised in data width and depth. It adds occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, overflow/underflow error pulses and an optional first-word-fall-through (FWFT) read mode. It sits between a single-clock producer and consumer and is the drop-in buffer for the next datapath revision.

---
 rtl/sync_fifo_param_if.sv | 30 +++
 rtl/sync_fifo_param.sv | 106 ++++++++++
 tb/tb_sync_fifo_param.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer handshake bundle for sync_fifo_param
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clear;
    logic              wr;
    logic [DATA_W-1:0] data_in;
    logic              rd;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output clear, wr, data_in, rd,
        input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  clear, wr, data_in, rd,
        output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with flags, flush and optional FWFT
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input  logic            clock,
    input  logic            rst,
    sync_fifo_param_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_nxt;
    logic              full_q;
    logic              empty_q;
    logic              af_q;
    logic              ae_q;
    logic              ovf_q;
    logic              unf_q;
    logic              rd_ok;
    logic              wr_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A full FIFO still takes a write when the same cycle pops the head.
    always_comb begin
        rd_ok     = bus.rd & ~empty_q;
        wr_ok     = bus.wr & (~full_q | rd_ok);
        count_nxt = count_q;
        if (bus.clear)
            count_nxt = '0;
        else if (wr_ok & ~rd_ok)
            count_nxt = count_q + CNT_W'(1);
        else if (rd_ok & ~wr_ok)
            count_nxt = count_q - CNT_W'(1);
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_nxt;
            full_q  <= (count_nxt == CNT_W'(DEPTH));
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= CNT_W'(AF_LEVEL));
            ae_q    <= (count_nxt <= CNT_W'(AE_LEVEL));
            if (bus.clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf_q  <= 1'b0;
                unf_q  <= 1'b0;
            end else begin
                if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
                if (rd_ok) rd_ptr <= next_ptr(rd_ptr);
                ovf_q <= bus.wr & ~wr_ok;
                unf_q <= bus.rd & ~rd_ok;
            end
        end
    end

    // Storage is not reset; rst gating keeps a write from landing while reset is held.
    always_ff @(posedge clock) begin
        if (rst && wr_ok && !bus.clear)
            mem[wr_ptr] <= bus.data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.data_out = empty_q ? '0 : mem[rd_ptr];
        end else begin : g_std
            logic [DATA_W-1:0] dout_q;
            always_ff @(posedge clock or negedge rst) begin
                if (!rst)
                    dout_q <= '0;
                else if (rd_ok && !bus.clear)
                    dout_q <= mem[rd_ptr];
            end
            assign bus.data_out = dout_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - randomized queue-model bench for sync_fifo_param, standard and FWFT builds
module tb_sync_fifo_param;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int AF     = 12;
    localparam int AE     = 4;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    always #5 clock = ~clock;

    sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus_std ();
    sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus_fw ();

    sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_std.slave)
    );

    sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
        .clock (clock),
        .rst   (rst),
        .bus   (bus_fw.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] exp_dout;
    logic              exp_ovf;
    logic              exp_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic c, input logic [DATA_W-1:0] d);
        bus_std.wr = w; bus_std.rd = r; bus_std.clear = c; bus_std.data_in = d;
        bus_fw.wr  = w; bus_fw.rd  = r; bus_fw.clear  = c; bus_fw.data_in  = d;
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = '0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    task automatic model_step();
        bit rd_ok;
        bit wr_ok;
        if (bus_std.clear) begin
            q.delete();
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end else begin
            rd_ok = bus_std.rd && (q.size() != 0);
            wr_ok = bus_std.wr && ((q.size() < DEPTH) || rd_ok);
            if (rd_ok) exp_dout = q.pop_front();
            if (wr_ok) q.push_back(bus_std.data_in);
            exp_ovf = bus_std.wr && !wr_ok;
            exp_unf = bus_std.rd && !rd_ok;
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [DATA_W-1:0] head;
        n    = q.size();
        head = (n == 0) ? '0 : q[0];
        check({tag, ".count"},    32'(bus_std.count),        32'(n));
        check({tag, ".full"},     32'(bus_std.full),         32'(n == DEPTH));
        check({tag, ".empty"},    32'(bus_std.empty),        32'(n == 0));
        check({tag, ".afull"},    32'(bus_std.almost_full),  32'(n >= AF));
        check({tag, ".aempty"},   32'(bus_std.almost_empty), 32'(n <= AE));
        check({tag, ".overflow"}, 32'(bus_std.overflow),     32'(exp_ovf));
        check({tag, ".underflow"},32'(bus_std.underflow),    32'(exp_unf));
        check({tag, ".dout"},     32'(bus_std.data_out),     32'(exp_dout));
        check({tag, ".fw_count"}, 32'(bus_fw.count),         32'(n));
        check({tag, ".fw_empty"}, 32'(bus_fw.empty),         32'(n == 0));
        check({tag, ".fw_dout"},  32'(bus_fw.data_out),      32'(head));
    endtask

    task automatic step(input logic w, input logic r, input logic c, input logic [DATA_W-1:0] d, input string tag);
        drive(w, r, c, d);
        model_step();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, '0);
        model_reset();
        repeat (3) begin
            @(posedge clock);
            #1;
            check_all("reset");
        end
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0, "idle");

        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'(i), "fill");
        step(1'b1, 1'b0, 1'b0, 8'h99, "ovf");
        step(1'b0, 1'b0, 1'b0, '0, "ovf_end");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0, "drain");

        step(1'b0, 1'b1, 1'b0, '0, "unf");
        step(1'b1, 1'b1, 1'b0, 8'hAA, "rdwr_empty");

        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom), "refill");
        step(1'b1, 1'b1, 1'b0, 8'h55, "rdwr_full");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0, "drain_wrap");

        step(1'b1, 1'b0, 1'b0, 8'h3C, "fwft_wr");
        step(1'b0, 1'b1, 1'b0, '0, "fwft_rd");

        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom), "load7");
        step(1'b1, 1'b0, 1'b1, 8'hEE, "clear");

        for (int blk = 0; blk < 40; blk++) begin
            int pw;
            pw = $urandom_range(10, 90);
            for (int k = 0; k < 60; k++)
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw),
                     $urandom_range(0, 63) == 0, 8'($urandom), "rand");
        end

        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom), "burst");
        drive(1'b1, 1'b0, 1'b0, 8'h77);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clock);
        #1;
        check_all("rst_hold");
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0, "post_rst");
        step(1'b0, 1'b1, 1'b0, '0, "post_rst_rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
